dff_pipeline: RTL and testbench
===============================

DFF_PIPELINE -- requirements
Module: dff_pipeline

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (>=1; 0 illegal, elaboration error).
REQ-003 SHALL have parameter RST_VAL, default 0, WIDTH-bit value loaded into every data stage on reset/clear.
REQ-004 SHALL have port clk input 1: single clock, all state on rising edge.
REQ-005 SHALL have port reset input 1: asynchronous, active-high reset.
REQ-006 SHALL have port en input 1: advance enable; low = whole chain holds.
REQ-007 SHALL have port sclr input 1: synchronous clear, active-high.
REQ-008 SHALL have port D input WIDTH: data into stage 0.
REQ-009 SHALL have port d_valid input 1: D carries a valid sample.
REQ-010 SHALL have port Q output WIDTH: data of stage DEPTH-1.
REQ-011 SHALL have port q_valid output 1: valid flag of stage DEPTH-1.
REQ-012 SHALL have port fill_cnt output $clog2(DEPTH+1): number of stages currently holding a valid flag.

Function
REQ-013 SHALL, on a clk edge with en=1 and sclr=0, load stage0 <= {D,d_valid} and stage i <= stage i-1 for i=1..DEPTH-1.
REQ-014 SHALL shift data unconditionally with en, regardless of valid flags; Q content is defined only when q_valid=1.
REQ-015 SHALL give latency of exactly DEPTH enabled edges from D/d_valid sample to Q/q_valid.
REQ-016 SHALL, with en=0 and sclr=0, hold all data, valid flags and fill_cnt unchanged; D/d_valid are ignored.
REQ-017 SHALL, on a clk edge with sclr=1, load all data stages with RST_VAL, clear all valid flags, set fill_cnt=0, independent of en.
REQ-018 SHALL give sclr priority over en and d_valid; a sample presented on a clearing edge is discarded.
REQ-019 SHALL update fill_cnt on enabled edges as fill_cnt + d_valid - q_valid (pre-edge q_valid), range 0..DEPTH, never wrapping.
REQ-020 SHALL keep fill_cnt equal to the popcount of valid flags at all times; with d_valid=1 and q_valid=1 simultaneously fill_cnt is unchanged.
REQ-021 SHALL drive Q and q_valid directly from stage DEPTH-1 registers (no combinational path from any input).
REQ-022 SHALL, for DEPTH=1, behave as a single enabled register with valid flag, fill_cnt 1 bit.

Reset
REQ-023 SHALL, while reset=1, immediately force all data stages to RST_VAL, all valid flags to 0, fill_cnt to 0; hence Q=RST_VAL, q_valid=0.
REQ-024 SHALL accept reset assertion at any point mid-stream; in-flight samples are lost, no partial state remains.
REQ-025 SHALL resume normal operation on the first clk edge after reset deassertion.

Configuration
REQ-026 SHALL, when macro DFF_PIPELINE_PARITY_EN is defined, carry one even-parity bit per stage (computed from D at stage 0) and add output parity_err (1 bit) = q_valid AND parity mismatch on Q; parity bits reset/clear to parity(RST_VAL).
REQ-027 SHALL, without DFF_PIPELINE_PARITY_EN, have no parity storage and no parity_err port.

Structure
REQ-028 SHALL place count-width helper function and default RST_VAL constant in shared package dff_pkg.
REQ-029 SHALL implement each stage as sub-module dff_stage (async reset, en, sclr, data+valid[+parity]), instantiated DEPTH times by generate loop.

Verification (WIDTH=8, DEPTH=4, RST_VAL=0)
REQ-030 SHALL check reset: reset=1 mid-stream with fill_cnt=3 -> Q=0x00, q_valid=0, fill_cnt=0 before next clk edge.
REQ-031 SHALL check latency: en=1, D=0xA5 d_valid=1 for one edge, then d_valid=0 -> Q=0xA5, q_valid=1 exactly after 4th edge, for one cycle; fill_cnt 1,1,1,1,0.
REQ-032 SHALL check stall: stream 0x01..0x04, drop en for 3 edges after second sample -> Q/fill_cnt frozen; output order 0x01..0x04 preserved, no duplicates.
REQ-033 SHALL check sclr priority: fill_cnt=4, sclr=1, en=1, d_valid=1, D=0x77 -> next edge fill_cnt=0, q_valid=0, 0x77 never appears at Q.
REQ-034 SHALL check full throughput: d_valid=1 every edge for 10 edges -> fill_cnt saturates at 4, Q delivers each sample once in order, 4 edges late.
REQ-035 SHALL check parity (macro defined): force a stage data bit flip on a valid sample 0x3C -> parity_err=1 when it reaches Q; 0 for all clean samples.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipeline delay line.
// Holds the default reset/clear value, the fill-counter width function
// and the even-parity helper used when DFF_PIPELINE_PARITY_EN is defined.
package dff_pkg;

  // Default value loaded into every data stage on reset/clear.
  localparam int unsigned DFF_RST_VAL = 0;

  // Bits needed to count 0..depth valid stages inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Even parity: the returned bit makes data+parity hold an even number of ones.
  function automatic logic even_par(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One register stage of the delay line: data word, valid flag and optional parity bit.
// Ports: clk, reset (async, active-high), en (advance), sclr (sync clear, wins over en),
//        dat_i/vld_i[/par_i] from the previous stage, dat_o/vld_o[/par_o] registered outputs.
// Parity storage exists only when DFF_PIPELINE_PARITY_EN is defined.
module dff_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sclr,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             vld_i,
`ifdef DFF_PIPELINE_PARITY_EN
  input  logic             par_i,
  output logic             par_o,
`endif
  output logic [WIDTH-1:0] dat_o,
  output logic             vld_o
);

  logic [WIDTH-1:0] dat_q, dat_d;
  logic             vld_q, vld_d;

`ifdef DFF_PIPELINE_PARITY_EN
  // Reset/clear parity matches RST_VAL so a cleared stage is self-consistent.
  localparam logic PAR_RST = ^RST_VAL;
  logic par_q, par_d;
`endif

  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
`ifdef DFF_PIPELINE_PARITY_EN
    par_d = par_q;
`endif
    if (sclr) begin
      dat_d = RST_VAL;
      vld_d = 1'b0;
`ifdef DFF_PIPELINE_PARITY_EN
      par_d = PAR_RST;
`endif
    end else if (en) begin
      dat_d = dat_i;
      vld_d = vld_i;
`ifdef DFF_PIPELINE_PARITY_EN
      par_d = par_i;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dat_q <= RST_VAL;
      vld_q <= 1'b0;
`ifdef DFF_PIPELINE_PARITY_EN
      par_q <= PAR_RST;
`endif
    end else begin
      dat_q <= dat_d;
      vld_q <= vld_d;
`ifdef DFF_PIPELINE_PARITY_EN
      par_q <= par_d;
`endif
    end
  end

  assign dat_o = dat_q;
  assign vld_o = vld_q;
`ifdef DFF_PIPELINE_PARITY_EN
  assign par_o = par_q;
`endif

endmodule

// File: rtl/dff_pipeline.sv
// DEPTH-stage enabled delay line with per-stage valid flags and an occupancy counter.
// Ports: clk, reset (async, active-high), en, sclr, D/d_valid in; Q/q_valid out (registered),
//        fill_cnt = number of valid stages; parity_err only with DFF_PIPELINE_PARITY_EN defined.
// Latency is DEPTH enabled edges; en=0 freezes everything, sclr empties the line.
module dff_pipeline
  import dff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DFF_RST_VAL)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      sclr,
  input  logic [WIDTH-1:0]          D,
  input  logic                      d_valid,
  output logic [WIDTH-1:0]          Q,
  output logic                      q_valid,
`ifdef DFF_PIPELINE_PARITY_EN
  output logic                      parity_err,
`endif
  output logic [cnt_w(DEPTH)-1:0]   fill_cnt
);

  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("dff_pipeline: DEPTH must be at least 1");
  end

  // Element i feeds stage i; element DEPTH is the last stage's output.
  logic [WIDTH-1:0] dat_chain [DEPTH+1];
  logic             vld_chain [DEPTH+1];
`ifdef DFF_PIPELINE_PARITY_EN
  logic             par_chain [DEPTH+1];
  assign par_chain[0] = even_par(64'(D));
`endif

  assign dat_chain[0] = D;
  assign vld_chain[0] = d_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    dff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .sclr  (sclr),
      .dat_i (dat_chain[i]),
      .vld_i (vld_chain[i]),
`ifdef DFF_PIPELINE_PARITY_EN
      .par_i (par_chain[i]),
      .par_o (par_chain[i+1]),
`endif
      .dat_o (dat_chain[i+1]),
      .vld_o (vld_chain[i+1])
    );
  end

  assign Q       = dat_chain[DEPTH];
  assign q_valid = vld_chain[DEPTH];

`ifdef DFF_PIPELINE_PARITY_EN
  assign parity_err = q_valid & (even_par(64'(Q)) != par_chain[DEPTH]);
`endif

  // Occupancy tracks the valid flags: one enters with d_valid, one leaves with the
  // pre-edge q_valid, so the count stays within 0..DEPTH without saturation logic.
  logic [CW-1:0] fill_q, fill_d;

  always_comb begin
    fill_d = fill_q;
    if (sclr) begin
      fill_d = '0;
    end else if (en) begin
      fill_d = fill_q + CW'(d_valid) - CW'(q_valid);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign fill_cnt = fill_q;

endmodule

// File: tb/tb_dff_pipeline.sv
module tb_dff_pipeline;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       sclr;
  logic [7:0] D;
  logic       d_valid;
  logic [7:0] Q;
  logic       q_valid;
  logic [2:0] fill_cnt;
`ifdef DFF_PIPELINE_PARITY_EN
  logic       parity_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dff_pipeline #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sclr       (sclr),
    .D          (D),
    .d_valid    (d_valid),
    .Q          (Q),
    .q_valid    (q_valid),
`ifdef DFF_PIPELINE_PARITY_EN
    .parity_err (parity_err),
`endif
    .fill_cnt   (fill_cnt)
  );

  typedef struct {
    logic       en;
    logic       sclr;
    logic [7:0] d;
    logic       dv;
    logic       chk_q;
    logic [7:0] q;
    logic       qv;
    logic [2:0] fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic s, input logic [7:0] d,
                              input logic dv, input logic cq, input logic [7:0] q,
                              input logic qv, input logic [2:0] fc);
    vec_t v;
    v.en = e; v.sclr = s; v.d = d; v.dv = dv;
    v.chk_q = cq; v.q = q; v.qv = qv; v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge happen, sample at the next falling edge.
  task automatic step(input logic e, input logic s, input logic [7:0] d, input logic dv);
    en = e; sclr = s; D = d; d_valid = dv;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single sample latency: fill 1,1,1,1,0; Q=A5 valid only after the 4th edge.
    vecs.push_back(mk(1, 0, 8'hA5, 1, 0, 8'h00, 0, 3'd1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 3'd1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 3'd1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'hA5, 1, 3'd1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 3'd0));
    // Stall after the second sample; D/d_valid ignored while en=0.
    vecs.push_back(mk(1, 0, 8'h01, 1, 0, 8'h00, 0, 3'd1));
    vecs.push_back(mk(1, 0, 8'h02, 1, 0, 8'h00, 0, 3'd2));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 0, 8'hFF, 1, 0, 8'h00, 0, 3'd2));
    vecs.push_back(mk(1, 0, 8'h03, 1, 0, 8'h00, 0, 3'd3));
    vecs.push_back(mk(1, 0, 8'h04, 1, 1, 8'h01, 1, 3'd4));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h02, 1, 3'd3));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h03, 1, 3'd2));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h04, 1, 3'd1));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 3'd0));
    // Full throughput: 10 back-to-back samples, then drain.
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(1, 0, 8'(8'h10 + k), 1, (k >= 3), 8'(8'h10 + k - 3), (k >= 3),
                        3'((k + 1 > 4) ? 4 : k + 1)));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'(8'h17 + k), 1, 3'(3 - k)));
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 0, 3'd0));
    // sclr beats en and d_valid: 0x77 must never reach Q.
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 0, 8'(8'h20 + k), 1, (k == 3), 8'h20, (k == 3), 3'(k + 1)));
    vecs.push_back(mk(1, 1, 8'h77, 1, 1, 8'h00, 0, 3'd0));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h00, 0, 3'd0));
    // sclr also clears while en=0.
    vecs.push_back(mk(1, 0, 8'h31, 1, 0, 8'h00, 0, 3'd1));
    vecs.push_back(mk(1, 0, 8'h32, 1, 0, 8'h00, 0, 3'd2));
    vecs.push_back(mk(0, 1, 8'h99, 1, 1, 8'h00, 0, 3'd0));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(1, 0, 8'h00, 0, 1, 8'h00, 0, 3'd0));

    reset = 1'b1; en = 1'b0; sclr = 1'b0; D = 8'h00; d_valid = 1'b0;
    #12;
    chk("rst_q", 32'(Q), 32'h00);
    chk("rst_qv", 32'(q_valid), 32'h0);
    chk("rst_fill", 32'(fill_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].sclr, vecs[i].d, vecs[i].dv);
      chk($sformatf("vec%0d_qv", i), 32'(q_valid), 32'(vecs[i].qv));
      chk($sformatf("vec%0d_fill", i), 32'(fill_cnt), 32'(vecs[i].fc));
      if (vecs[i].chk_q) chk($sformatf("vec%0d_q", i), 32'(Q), 32'(vecs[i].q));
`ifdef DFF_PIPELINE_PARITY_EN
      chk($sformatf("vec%0d_perr", i), 32'(parity_err), 32'h0);
`endif
    end

    // Asynchronous reset mid-stream with three samples in flight.
    step(1, 0, 8'h41, 1);
    step(1, 0, 8'h42, 1);
    step(1, 0, 8'h43, 1);
    chk("pre_rst_fill", 32'(fill_cnt), 32'h3);
    reset = 1'b1;
    #1;
    chk("mid_rst_q", 32'(Q), 32'h00);
    chk("mid_rst_qv", 32'(q_valid), 32'h0);
    chk("mid_rst_fill", 32'(fill_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    // First edge after release already loads; nothing from before the reset survives.
    step(1, 0, 8'h44, 1);
    chk("post_rst_fill", 32'(fill_cnt), 32'h1);
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 8'h00, 0);
      chk("post_rst_qv_lo", 32'(q_valid), 32'h0);
    end
    step(1, 0, 8'h00, 0);
    chk("post_rst_q", 32'(Q), 32'h44);
    chk("post_rst_qv", 32'(q_valid), 32'h1);
    chk("post_rst_fill1", 32'(fill_cnt), 32'h1);
    step(1, 0, 8'h00, 0);
    chk("post_rst_drain", 32'(fill_cnt), 32'h0);

`ifdef DFF_PIPELINE_PARITY_EN
    // Corrupt one data bit of 0x3C while it sits in stage 1.
    step(1, 0, 8'h3C, 1);
    step(1, 0, 8'h00, 0);
    en = 1'b0;
    force dut.g_stage[1].u_stage.dat_q = 8'h3D;
    #1;
    release dut.g_stage[1].u_stage.dat_q;
    step(1, 0, 8'h00, 0);
    chk("par_bad_qv_lo", 32'(q_valid), 32'h0);
    step(1, 0, 8'h00, 0);
    chk("par_bad_qv", 32'(q_valid), 32'h1);
    chk("par_bad_err", 32'(parity_err), 32'h1);
    step(1, 0, 8'h5A, 1);
    for (int k = 0; k < 3; k++) step(1, 0, 8'h00, 0);
    chk("par_clean_q", 32'(Q), 32'h5A);
    chk("par_clean_err", 32'(parity_err), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
